cmp_flag_monitor: RTL and testbench
===================================

CMP_FLAG_MONITOR -- requirements
Module: cmp_flag_monitor

Interface
REQ-001 SHALL have parameter LOCK_N, default 3, number of consecutive legal equal samples needed to assert lock; legal range 1..7.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  e/l/g sample qualifier from the upstream 2-bit comparator stage.
REQ-005 SHALL have port e  input  1  comparator equal flag (a==b).
REQ-006 SHALL have port l  input  1  comparator less flag (a<b).
REQ-007 SHALL have port g  input  1  comparator greater flag (a>b).
REQ-008 SHALL have port clr  input  1  synchronous clear of counters, FSM and error.
REQ-009 SHALL have port eq_cnt  output  8  saturating count of legal equal samples.
REQ-010 SHALL have port lt_cnt  output  8  saturating count of legal less samples.
REQ-011 SHALL have port gt_cnt  output  8  saturating count of legal greater samples.
REQ-012 SHALL have port streak  output  3  current run length of consecutive legal equal samples.
REQ-013 SHALL have port lock  output  1  high while FSM is in LOCKED.
REQ-014 SHALL have port err  output  1  high while FSM is in ERR (sticky).

Function
REQ-015 Sample SHALL be legal when in_valid=1 and exactly one of e, l, g is 1; illegal when in_valid=1 and any other combination of e, l, g (000, 011, 101, 110, 111).
REQ-016 in_valid=0 cycles SHALL leave all state and outputs unchanged, whatever e/l/g hold.
REQ-017 All outputs SHALL be registered; effect of a sample at edge N SHALL be visible after edge N (1-cycle latency).
REQ-018 Each legal sample SHALL increment exactly one of eq_cnt/lt_cnt/gt_cnt by 1, holding at 255 (no wrap).
REQ-019 Illegal samples SHALL NOT change any counter.
REQ-020 FSM states SHALL be SEARCH, COUNT, LOCKED, ERR, encoded internally.
REQ-021 SEARCH: legal e -> streak=1, go COUNT (go LOCKED if LOCK_N=1); legal l/g -> stay, streak=0.
REQ-022 COUNT: legal e -> streak+1, go LOCKED when streak+1 = LOCK_N; legal l/g -> SEARCH, streak=0.
REQ-023 LOCKED: legal e -> stay, streak holds at LOCK_N; legal l/g -> SEARCH, streak=0, lock falls after that edge.
REQ-024 Any state: illegal sample -> ERR, streak=0; ERR SHALL be exited only by clr or rst; samples in ERR SHALL be ignored for FSM but legal samples SHALL still update counters.
REQ-025 clr=1 SHALL zero all counters and streak, FSM -> SEARCH, err=0, lock=0; clr SHALL take priority over a same-cycle sample (sample discarded).
REQ-026 lock and err SHALL never be high simultaneously.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force eq_cnt=lt_cnt=gt_cnt=0, streak=0, lock=0, err=0, FSM=SEARCH.
REQ-028 Reset asserted mid-streak or in LOCKED/ERR SHALL discard all state; first legal sample after rst release SHALL be treated as from SEARCH.

Verification
REQ-029 LOCK_N=3; legal e,e,e on consecutive valid cycles -> streak 1,2,3; lock=1 after 3rd edge; eq_cnt=3.
REQ-030 Locked, then legal l (a=01,b=10 -> e=0,l=1,g=0) -> lock=0, streak=0, lt_cnt+1 next cycle; then e,e -> streak=2, lock=0.
REQ-031 e,valid=0 gap,e,e -> lock=1 after 3rd valid sample (gaps do not break streak).
REQ-032 e=1,l=1,g=0 valid -> err=1, counters unchanged; then legal g -> gt_cnt+1, err stays 1; clr -> all zero, err=0.
REQ-033 300 legal g samples -> gt_cnt=255, eq_cnt=lt_cnt=0; clr with same-cycle valid e -> eq_cnt=0.
REQ-034 rst pulse between clock edges while LOCKED with eq_cnt=5 -> lock=0, eq_cnt=0, streak=0 before next edge.

Source files
------------

// File: rtl/cmp_flag_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cmp_flag_monitor
// Description : Monitors e/l/g flags from a comparator stage. It keeps
//               saturating per-flag counters and an equal-streak lock FSM
//               with a sticky error state for illegal flag combinations.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_flag_monitor #(
    parameter int LOCK_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       e,
    input  logic       l,
    input  logic       g,
    input  logic       clr,
    output logic [7:0] eq_cnt,
    output logic [7:0] lt_cnt,
    output logic [7:0] gt_cnt,
    output logic [2:0] streak,
    output logic       lock,
    output logic       err
);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_COUNT  = 2'd1,
        S_LOCKED = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [2:0] C_LOCK_N = 3'(LOCK_N);
    localparam logic [7:0] C_SAT    = 8'hFF;

    state_t     r_state;
    logic [7:0] r_eq_cnt;
    logic [7:0] r_lt_cnt;
    logic [7:0] r_gt_cnt;
    logic [2:0] r_streak;
    logic       r_lock;
    logic       r_err;

    logic       w_onehot;
    logic       w_legal;

    assign w_onehot = ({e, l, g} == 3'b100) || ({e, l, g} == 3'b010) ||
                      ({e, l, g} == 3'b001);
    assign w_legal  = in_valid & w_onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_SEARCH;
            r_eq_cnt <= 8'd0;
            r_lt_cnt <= 8'd0;
            r_gt_cnt <= 8'd0;
            r_streak <= 3'd0;
            r_lock   <= 1'b0;
            r_err    <= 1'b0;
        end else if (clr) begin
            r_state  <= S_SEARCH;
            r_eq_cnt <= 8'd0;
            r_lt_cnt <= 8'd0;
            r_gt_cnt <= 8'd0;
            r_streak <= 3'd0;
            r_lock   <= 1'b0;
            r_err    <= 1'b0;
        end else if (in_valid) begin
            // Counters keep running even while the FSM sits in ERR.
            if (w_legal) begin
                if (e && r_eq_cnt != C_SAT) r_eq_cnt <= r_eq_cnt + 8'd1;
                if (l && r_lt_cnt != C_SAT) r_lt_cnt <= r_lt_cnt + 8'd1;
                if (g && r_gt_cnt != C_SAT) r_gt_cnt <= r_gt_cnt + 8'd1;
            end

            if (r_state != S_ERR) begin
                if (!w_legal) begin
                    r_state  <= S_ERR;
                    r_streak <= 3'd0;
                    r_lock   <= 1'b0;
                    r_err    <= 1'b1;
                end else if (e) begin
                    case (r_state)
                        S_SEARCH: begin
                            r_streak <= 3'd1;
                            if (C_LOCK_N == 3'd1) begin
                                r_state <= S_LOCKED;
                                r_lock  <= 1'b1;
                            end else begin
                                r_state <= S_COUNT;
                            end
                        end
                        S_COUNT: begin
                            r_streak <= r_streak + 3'd1;
                            if (r_streak + 3'd1 == C_LOCK_N) begin
                                r_state <= S_LOCKED;
                                r_lock  <= 1'b1;
                            end
                        end
                        default: begin
                            r_streak <= C_LOCK_N;
                        end
                    endcase
                end else begin
                    r_state  <= S_SEARCH;
                    r_streak <= 3'd0;
                    r_lock   <= 1'b0;
                end
            end
        end
    end

    assign eq_cnt = r_eq_cnt;
    assign lt_cnt = r_lt_cnt;
    assign gt_cnt = r_gt_cnt;
    assign streak = r_streak;
    assign lock   = r_lock;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cmp_flag_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_flag_monitor
// Description : Directed vector table plus multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_flag_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       e = 1'b0;
    logic       l = 1'b0;
    logic       g = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] eq_cnt, lt_cnt, gt_cnt;
    logic [2:0] streak;
    logic       lock, err;

    int n_cmp = 0;
    int n_bad = 0;

    cmp_flag_monitor #(.LOCK_N(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .e(e), .l(l), .g(g),
        .clr(clr), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .gt_cnt(gt_cnt),
        .streak(streak), .lock(lock), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       c, v, fe, fl, fg;
        logic [7:0] x_eq, x_lt, x_gt;
        logic [2:0] x_st;
        logic       x_lk, x_er;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int xe, input int xl, input int xg,
                           input int xs, input int xk, input int xr);
        chk({tag, ".eq_cnt"}, int'(eq_cnt), xe);
        chk({tag, ".lt_cnt"}, int'(lt_cnt), xl);
        chk({tag, ".gt_cnt"}, int'(gt_cnt), xg);
        chk({tag, ".streak"}, int'(streak), xs);
        chk({tag, ".lock"},   int'(lock),   xk);
        chk({tag, ".err"},    int'(err),    xr);
        if (lock && err) chk({tag, ".lock_and_err"}, 1, 0);
    endtask

    task automatic step(input logic c, input logic v, input logic fe,
                        input logic fl, input logic fg);
        clr = c; in_valid = v; e = fe; l = fl; g = fg;
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0; e = 1'b0; l = 1'b0; g = 1'b0;
    endtask

    initial begin
        //            c v e l g  eq lt gt st lk er
        tbl[0]  = '{0,1,1,0,0, 1, 0, 0, 1, 0, 0};
        tbl[1]  = '{0,1,1,0,0, 2, 0, 0, 2, 0, 0};
        tbl[2]  = '{0,1,1,0,0, 3, 0, 0, 3, 1, 0};
        tbl[3]  = '{0,1,1,0,0, 4, 0, 0, 3, 1, 0};
        tbl[4]  = '{0,1,0,1,0, 4, 1, 0, 0, 0, 0};
        tbl[5]  = '{0,1,1,0,0, 5, 1, 0, 1, 0, 0};
        tbl[6]  = '{0,1,1,0,0, 6, 1, 0, 2, 0, 0};
        tbl[7]  = '{0,0,1,0,0, 6, 1, 0, 2, 0, 0};
        tbl[8]  = '{0,1,1,0,0, 7, 1, 0, 3, 1, 0};
        tbl[9]  = '{0,1,0,0,1, 7, 1, 1, 0, 0, 0};
        tbl[10] = '{0,0,1,1,0, 7, 1, 1, 0, 0, 0};
        tbl[11] = '{0,1,0,0,0, 7, 1, 1, 0, 0, 1};
        tbl[12] = '{0,1,1,1,0, 7, 1, 1, 0, 0, 1};
        tbl[13] = '{0,1,0,0,1, 7, 1, 2, 0, 0, 1};
        tbl[14] = '{0,1,1,0,0, 8, 1, 2, 0, 0, 1};
        tbl[15] = '{1,1,1,0,0, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{0,1,1,0,0, 1, 0, 0, 1, 0, 0};
        tbl[17] = '{0,1,1,1,1, 1, 0, 0, 0, 0, 1};
        tbl[18] = '{1,0,0,0,0, 0, 0, 0, 0, 0, 0};
        tbl[19] = '{0,1,0,1,1, 0, 0, 0, 0, 0, 1};
        tbl[20] = '{1,0,0,0,0, 0, 0, 0, 0, 0, 0};

        // Reset state, sampled while rst is still held.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].v, tbl[i].fe, tbl[i].fl, tbl[i].fg);
            chk_all($sformatf("vec%0d", i), tbl[i].x_eq, tbl[i].x_lt,
                    tbl[i].x_gt, tbl[i].x_st, tbl[i].x_lk, tbl[i].x_er);
        end

        // gt counter saturation, then clr wins over a same-cycle sample.
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_all("sat", 0, 0, 255, 0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("clr_prio", 0, 0, 0, 0, 0, 0);

        // Async reset between edges while LOCKED with eq_cnt=5.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("pre_rst", 5, 0, 0, 3, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("post_rst", 1, 0, 0, 1, 0, 0);

        // Reset out of ERR also clears the sticky flag.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("err_again", 1, 0, 0, 0, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk_all("rst_err", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("post_rst_err", 0, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
